// File: rtl/detection_sequencer.sv
// detection_sequencer: captures a frame into the integral-image buffer, then rasters a WIN x WIN window over it, one classifier run per origin.
// Ports: clk; rst (sync, active-low); cap_sof/cap_we/cap_addr/cap_done capture side;
// cont_mode/continue_in re-arm; det_en/det_addr/det_done/det_hit classifier handshake;
// buf_addr/buf_we buffer port A; win_x/win_y window origin; hit_count/frame_done scan result; busy.
// Define DETSEQ_EARLY_EXIT_EN to stop the scan at the first positive window.
module detection_sequencer #(
    parameter int ADDR_W = 15,
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int WIN    = 24,
    parameter int STEP   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_sof,
    input  logic              cap_we,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic              cap_done,
    input  logic              cont_mode,
    input  logic              continue_in,
    output logic              det_en,
    input  logic [ADDR_W-1:0] det_addr,
    input  logic              det_done,
    input  logic              det_hit,
    output logic [ADDR_W-1:0] buf_addr,
    output logic              buf_we,
    output logic [15:0]       win_x,
    output logic [15:0]       win_y,
    output logic [15:0]       hit_count,
    output logic              frame_done,
    output logic              busy
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ARM      = 3'd1;
    localparam logic [2:0] CAPTURE  = 3'd2;
    localparam logic [2:0] START    = 3'd3;
    localparam logic [2:0] WAIT_DET = 3'd4;
    localparam logic [2:0] ADVANCE  = 3'd5;
    localparam logic [2:0] HOLD     = 3'd6;
    // A window that does not fit the image yields an empty scan.
    localparam bit SKIP = (WIN > IMG_W) || (WIN > IMG_H);

    logic [2:0]  state;
    logic [15:0] acc;
    logic [15:0] acc_inc;
    logic        cont_q;
    logic        x_fits;
    logic        y_fits;
    logic        scanning;

    always_comb begin
        acc_inc  = (acc == 16'hFFFF) ? acc : acc + 16'(det_hit);
        x_fits   = 32'(win_x) + 32'(STEP) + 32'(WIN) <= 32'(IMG_W);
        y_fits   = 32'(win_y) + 32'(STEP) + 32'(WIN) <= 32'(IMG_H);
        scanning = (state == START) || (state == WAIT_DET) || (state == ADVANCE);
    end

    assign det_en   = state == START;
    assign busy     = (state != IDLE) && (state != ARM);
    assign buf_we   = (state == CAPTURE) && cap_we;
    assign buf_addr = (state == CAPTURE) ? cap_addr :
                      scanning ? ADDR_W'(32'(win_y) * 32'(IMG_W) + 32'(win_x) + 32'(det_addr)) :
                      '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            win_x      <= '0;
            win_y      <= '0;
            hit_count  <= '0;
            frame_done <= 1'b0;
            acc        <= '0;
            cont_q     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Continue edges only count while parked in HOLD; cont_q tracks the level everywhere.
            cont_q     <= continue_in;
            case (state)
                IDLE: state <= ARM;
                ARM: if (cap_sof) state <= CAPTURE;
                CAPTURE: if (cap_done) begin
                    win_x <= '0;
                    win_y <= '0;
                    acc   <= '0;
                    if (SKIP) begin
                        state      <= HOLD;
                        hit_count  <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        state <= START;
                    end
                end
                START: state <= WAIT_DET;
                WAIT_DET: if (det_done) begin
                    acc <= acc_inc;
`ifdef DETSEQ_EARLY_EXIT_EN
                    if (det_hit) begin
                        state      <= HOLD;
                        hit_count  <= acc_inc;
                        frame_done <= 1'b1;
                    end else begin
                        state <= ADVANCE;
                    end
`else
                    state <= ADVANCE;
`endif
                end
                ADVANCE: if (x_fits) begin
                    win_x <= win_x + 16'(STEP);
                    state <= START;
                end else if (y_fits) begin
                    win_x <= '0;
                    win_y <= win_y + 16'(STEP);
                    state <= START;
                end else begin
                    state      <= HOLD;
                    hit_count  <= acc;
                    frame_done <= 1'b1;
                end
                HOLD: if (cont_mode || (continue_in && !cont_q)) state <= ARM;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_detection_sequencer.sv
// tb_detection_sequencer: directed scenarios on a 32x32 image with a 24-pixel window and stride 4.
module tb_detection_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cap_sof = 1'b0;
    logic        cap_we = 1'b0;
    logic [14:0] cap_addr = '0;
    logic        cap_done = 1'b0;
    logic        cont_mode = 1'b0;
    logic        continue_in = 1'b0;
    logic        det_en;
    logic [14:0] det_addr = 15'd5;
    logic        det_done = 1'b0;
    logic        det_hit = 1'b0;
    logic [14:0] buf_addr;
    logic        buf_we;
    logic [15:0] win_x;
    logic [15:0] win_y;
    logic [15:0] hit_count;
    logic        frame_done;
    logic        busy;
    int          vectors = 0;
    int          errs = 0;
    int          n_en;
    int          n_fd;

    detection_sequencer #(.ADDR_W(15), .IMG_W(32), .IMG_H(32), .WIN(24), .STEP(4)) dut (
        .clk(clk), .rst(rst), .cap_sof(cap_sof), .cap_we(cap_we), .cap_addr(cap_addr),
        .cap_done(cap_done), .cont_mode(cont_mode), .continue_in(continue_in),
        .det_en(det_en), .det_addr(det_addr), .det_done(det_done), .det_hit(det_hit),
        .buf_addr(buf_addr), .buf_we(buf_we), .win_x(win_x), .win_y(win_y),
        .hit_count(hit_count), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".buf_addr"}, 32'(buf_addr), 0);
        check({tag, ".buf_we"}, 32'(buf_we), 0);
        check({tag, ".det_en"}, 32'(det_en), 0);
        check({tag, ".win_x"}, 32'(win_x), 0);
        check({tag, ".win_y"}, 32'(win_y), 0);
        check({tag, ".hit_count"}, 32'(hit_count), 0);
        check({tag, ".frame_done"}, 32'(frame_done), 0);
        check({tag, ".busy"}, 32'(busy), 0);
    endtask

    task automatic capture(input int n);
        cap_sof = 1'b1;
        @(negedge clk);
        cap_sof = 1'b0;
        check("cap.busy", 32'(busy), 1);
        for (int i = 0; i < n; i++) begin
            cap_we = 1'b1;
            cap_addr = 15'(i);
            #1;
            check("cap.buf_addr", 32'(buf_addr), 32'(i));
            check("cap.buf_we", 32'(buf_we), 1);
            @(negedge clk);
        end
        cap_we = 1'b0;
        cap_done = 1'b1;
        @(negedge clk);
        cap_done = 1'b0;
    endtask

    task automatic scan(input logic [8:0] hits, input int abort_at, output int en, output int fd);
        int cd = 0;
        en = 0;
        fd = 0;
        for (int c = 0; c < 70; c++) begin
            det_done = 1'b0;
            det_hit = 1'b0;
            if (frame_done) fd++;
            if (det_en) begin
                check("scan.win_x", 32'(win_x), 32'((en % 3) * 4));
                check("scan.win_y", 32'(win_y), 32'((en / 3) * 4));
                check("scan.buf_addr", 32'(buf_addr), 32'((en / 3) * 4 * 32 + (en % 3) * 4 + 5));
                check("scan.buf_we", 32'(buf_we), 0);
                en++;
                cd = 3;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    det_done = 1'b1;
                    det_hit = hits[en - 1];
                    if (en - 1 == abort_at) begin
                        rst = 1'b0;
                        @(negedge clk);
                        check_zero("abort");
                        rst = 1'b1;
                        det_done = 1'b0;
                        det_hit = 1'b0;
                        return;
                    end
                end
            end
            @(negedge clk);
        end
        det_done = 1'b0;
        det_hit = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check("arm.busy", 32'(busy), 0);
        continue_in = 1'b1;

        capture(1024);
        scan(9'b0, -1, n_en, n_fd);
        check("s1.det_en_count", 32'(n_en), 9);
        check("s1.frame_done_count", 32'(n_fd), 1);
        check("s1.hit_count", 32'(hit_count), 0);
        check("hold.busy", 32'(busy), 1);

        cap_sof = 1'b1;
        cap_we = 1'b1;
        @(negedge clk);
        check("hold.sof_ignored", 32'(buf_we), 0);
        cap_sof = 1'b0;
        cap_we = 1'b0;
        continue_in = 1'b0;
        @(negedge clk);
        check("hold.level_no_exit", 32'(busy), 1);
        continue_in = 1'b1;
        @(negedge clk);
        check("hold.edge_exit", 32'(busy), 0);

        capture(4);
        scan(9'b001000010, -1, n_en, n_fd);
`ifdef DETSEQ_EARLY_EXIT_EN
        check("s2.det_en_count", 32'(n_en), 2);
        check("s2.hit_count", 32'(hit_count), 1);
`else
        check("s2.det_en_count", 32'(n_en), 9);
        check("s2.hit_count", 32'(hit_count), 2);
`endif
        check("s2.frame_done_count", 32'(n_fd), 1);
        check("s2.hold_busy", 32'(busy), 1);
        cont_mode = 1'b1;
        @(negedge clk);
        check("cont_mode.exit", 32'(busy), 0);
        cont_mode = 1'b0;

        capture(2);
        scan(9'b000010000, 4, n_en, n_fd);
        check("abort.det_en_count", 32'(n_en), 5);
        @(negedge clk);
        check("abort.arm_busy", 32'(busy), 0);
        capture(1);
        scan(9'b0, -1, n_en, n_fd);
        check("s3.det_en_count", 32'(n_en), 9);
        check("s3.frame_done_count", 32'(n_fd), 1);
        check("s3.hit_count", 32'(hit_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
